// File: rtl/bram_capture_pkg.sv
// Shared constants for the BRAM capture controller: FSM encodings,
// wishbone register map and CTRL command bit positions.
// No logic; imported by bram_capture_regs and bram_capture_ctrl.
package bram_capture_pkg;

  // Capture FSM encodings (also the value returned in STATUS[1:0])
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Register word addresses
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_LENGTH = 8'h01;
  localparam logic [7:0] REG_STATUS = 8'h02;
  localparam logic [7:0] REG_COUNT  = 8'h03;

  // CTRL command bits (write-only, self-clearing)
  localparam int CTRL_ARM_BIT    = 0;
  localparam int CTRL_SWTRIG_BIT = 1;
  localparam int CTRL_ABORT_BIT  = 2;

endpackage

// File: rtl/bram_capture_regs.sv
// Purpose: wishbone classic register file for the capture controller (CTRL/LENGTH/STATUS/COUNT).
// Latency: ack, read data and LENGTH update registered one cycle after the strobe; cmd_* are same-cycle decodes.
// Backpressure: none; a held strobe is acked every other cycle.
// Ports: wbs_* slave bus; state/count from the FSM; length and cmd_arm/cmd_swtrig/cmd_abort to the FSM.
module bram_capture_regs
  import bram_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  input  logic [1:0]            state,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   length,
  output logic                  cmd_arm,
  output logic                  cmd_swtrig,
  output logic                  cmd_abort
);

  localparam logic [ADDR_WIDTH:0] FULL_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic        req;
  logic        wr;
  logic        ctrl_wr;
  logic [31:0] rdata;
  logic        unused_dat;

  // A transfer is accepted in the cycle before ack rises; the ack cycle
  // itself never re-accepts, which yields the every-other-cycle rhythm.
  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr      = req & wbs_we_i;
  assign ctrl_wr = wr && (wbs_adr_i == REG_CTRL);

  // Commands act on the same edge that raises ack, so they are not registered here.
  assign cmd_arm    = ctrl_wr & wbs_dat_i[CTRL_ARM_BIT];
  assign cmd_swtrig = ctrl_wr & wbs_dat_i[CTRL_SWTRIG_BIT];
  assign cmd_abort  = ctrl_wr & wbs_dat_i[CTRL_ABORT_BIT];

  assign unused_dat = ^wbs_dat_i;

  always_comb begin
    rdata = '0;
    case (wbs_adr_i)
      REG_LENGTH: rdata[ADDR_WIDTH:0] = length;
      REG_STATUS: begin
        rdata[1:0] = state;
        rdata[2]   = (state == ST_DONE);
      end
      REG_COUNT:  rdata[ADDR_WIDTH:0] = count;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      length    <= FULL_DEPTH;
    end else begin
      wbs_ack_o <= req;
      if (req) begin
        wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
      end
      // LENGTH is frozen while a capture is pending or running.
      if (wr && (wbs_adr_i == REG_LENGTH) &&
          (state != ST_ARMED) && (state != ST_CAPTURE)) begin
        length <= wbs_dat_i[ADDR_WIDTH:0];
      end
    end
  end

endmodule

// File: rtl/bram_capture_ctrl.sv
// Purpose: triggered ADC sample capture into a BRAM write port, controlled over wishbone.
// Latency: fabric write port registered, 1 cycle after the valid sample; commands act on the ack edge.
// Backpressure: none; samples with adc_valid_i outside CAPTURE are dropped.
// Ports: wbs_* register bus, adc_data_i/adc_valid_i/trig_i sample input, fabric_* BRAM write port, capture_done_o.
module bram_capture_ctrl
  import bram_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  wbs_clk_i,
  input  logic                  wbs_rst_n_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  input  logic                  adc_valid_i,
  input  logic                  trig_i,
  output logic                  fabric_we,
  output logic [ADDR_WIDTH-1:0] fabric_addr,
  output logic [DATA_WIDTH-1:0] fabric_data_in,
  output logic                  capture_done_o
);

  localparam logic [ADDR_WIDTH:0] FULL_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [ADDR_WIDTH:0] count;
  logic [ADDR_WIDTH:0] count_nxt;
  logic [ADDR_WIDTH:0] length;
  logic [ADDR_WIDTH:0] eff_len;
  logic                cmd_arm;
  logic                cmd_swtrig;
  logic                cmd_abort;

  bram_capture_regs #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regs (
    .clk        (wbs_clk_i),
    .rst_n      (wbs_rst_n_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .state      (state),
    .count      (count),
    .length     (length),
    .cmd_arm    (cmd_arm),
    .cmd_swtrig (cmd_swtrig),
    .cmd_abort  (cmd_abort)
  );

  // Zero or oversize LENGTH means a full-depth capture, which also
  // guarantees the address never wraps within one capture.
  always_comb begin
    eff_len = length;
    if ((length == '0) || (length > FULL_DEPTH)) begin
      eff_len = FULL_DEPTH;
    end
  end

  assign count_nxt      = count + ONE;
  assign capture_done_o = (state == ST_DONE);

  always_ff @(posedge wbs_clk_i) begin
    if (!wbs_rst_n_i) begin
      state          <= ST_IDLE;
      count          <= '0;
      fabric_we      <= 1'b0;
      fabric_addr    <= '0;
      fabric_data_in <= '0;
    end else begin
      fabric_we <= 1'b0;
      if (cmd_abort) begin
        // Abort beats a simultaneous ARM; COUNT is kept for post-mortem reads.
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (cmd_arm) begin
              state <= ST_ARMED;
              count <= '0;
            end
          end
          ST_ARMED: begin
            if (trig_i || cmd_swtrig) begin
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (adc_valid_i) begin
              fabric_we      <= 1'b1;
              fabric_addr    <= count[ADDR_WIDTH-1:0];
              fabric_data_in <= adc_data_i;
              count          <= count_nxt;
              if (count_nxt == eff_len) begin
                state <= ST_DONE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bram_capture_ctrl.md
BRAM_CAPTURE_CTRL -- requirements
Module: bram_capture_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of sample data and BRAM fabric data.
REQ-002 Parameter ADDR_WIDTH, default 8: BRAM fabric address width; capture depth is up to 2^ADDR_WIDTH samples.
REQ-003 wbs_clk_i  in  1  single clock for all logic; the design SHALL have one clock, and reset is synchronous and active-low.
REQ-004 wbs_rst_n_i  in  1  synchronous active-low reset.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  wishbone classic slave strobes.
REQ-006 wbs_adr_i  in  8  register word address.
REQ-007 wbs_dat_i  in  32  write data.
REQ-008 wbs_dat_o  out  32  read data.
REQ-009 wbs_ack_o  out  1  transfer acknowledge.
REQ-010 adc_data_i  in  DATA_WIDTH  sample stream.
REQ-011 adc_valid_i  in  1  sample qualifier.
REQ-012 trig_i  in  1  external trigger, level-sampled.
REQ-013 fabric_we, fabric_addr[ADDR_WIDTH], fabric_data_in[DATA_WIDTH]  out  drive the BRAM fabric write port.
REQ-014 capture_done_o  out  1  high while in DONE.

Function
REQ-015 Registers: 0x00 CTRL (write-only, self-clearing: bit0 ARM, bit1 SWTRIG, bit2 ABORT); 0x01 LENGTH[ADDR_WIDTH:0] (R/W); 0x02 STATUS (RO: bits1:0 state, bit2 done); 0x03 COUNT[ADDR_WIDTH:0] (RO, samples written).
REQ-016 Ack rule: wbs_ack_o = 1 exactly one cycle after a cycle with cyc&stb&!ack; it is a one-cycle pulse; a held strobe is acked every other cycle.
REQ-017 Write side effects and read data take effect and are registered on the same edge that raises ack; CTRL reads 0; unmapped addresses read 0, and writes to them are ignored.
REQ-018 Writes to LENGTH are ignored in ARMED and CAPTURE; LENGTH 0 or greater than 2^ADDR_WIDTH means 2^ADDR_WIDTH.
REQ-019 FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-020 IDLE or DONE + ARM -> ARMED; COUNT is cleared to 0.
REQ-021 ARMED + (trig_i | SWTRIG) -> CAPTURE on the next edge; samples on the trigger cycle are not captured.
REQ-022 In CAPTURE, each cycle with adc_valid_i=1 writes one sample: fabric_we=1, fabric_addr=COUNT[ADDR_WIDTH-1:0], fabric_data_in=adc_data_i, all registered (1-cycle latency); COUNT then increments.
REQ-023 When COUNT reaches the effective LENGTH, the FSM moves to DONE on the same edge as the last write; no further writes occur.
REQ-024 ABORT in any state -> IDLE with fabric_we=0; COUNT is held.
REQ-025 ABORT and ARM written together: ABORT wins.
REQ-026 ARM in ARMED or CAPTURE is ignored; SWTRIG outside ARMED is ignored.
REQ-027 fabric_we=0 in every cycle not covered by REQ-022; fabric_addr never wraps within a capture.

Reset
REQ-028 On wbs_rst_n_i=0 at a clock edge: state=IDLE, COUNT=0, LENGTH=2^ADDR_WIDTH, wbs_ack_o=0, wbs_dat_o=0, fabric_we=0, fabric_addr=0, fabric_data_in=0, capture_done_o=0.
REQ-029 Reset asserted mid-capture terminates it within the same edge; no write is issued on the following cycle.

Structure
REQ-030 Shared package bram_capture_pkg SHALL hold: state encodings, register addresses 0x00-0x03, and CTRL bit positions.
REQ-031 The wishbone register file SHALL be the sub-module bram_capture_regs; the FSM and write datapath SHALL be in the top level.

Verification
REQ-032 Reset, then read LENGTH and STATUS -> 0x100 and 0; each ack is exactly one cycle wide, one cycle after stb.
REQ-033 LENGTH=4, ARM, SWTRIG, valid samples 0xA0..0xA5 -> writes to addr 0..3 with data 0xA0..0xA3, then STATUS=0x7, COUNT=4, capture_done_o=1.
REQ-034 adc_valid_i toggling 1,0,1,0 during CAPTURE with LENGTH=2 -> exactly 2 writes at addr 0,1; no fabric_we on invalid cycles.
REQ-035 LENGTH=0, trig_i pulse, continuous valid -> 256 writes at addr 0..255, then DONE, with no address wrap.
REQ-036 ABORT after 3 of 8 samples -> IDLE, COUNT=3, fabric_we=0; a LENGTH write during CAPTURE leaves LENGTH unchanged.
REQ-037 wbs_rst_n_i=0 for one cycle mid-capture -> the REQ-028 values appear on the next cycle, with no stray fabric_we.
